cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Run/step/halt sequencer for the 16-bit simplified MIPS CPU. Drives the CPU's per-instruction
//  enable and restart, halts on the 0xFFFF halt word, and pauses on an optional PC breakpoint.
//  Sits between the test/debug host and the CPU; observes the CPU's PC and IR only.
// PARAMETERS
//  DATA_WIDTH  16        width of pc, ir, bp_addr
//  HALT_INSTR  16'hFFFF  IR value that stops execution; this instruction never executes
//  CNT_WIDTH   16        width of instr_count
// PORTS
//  clock        in   1           system clock, rising edge
//  reset        in   1           synchronous, active-high
//  start        in   1           pulse: IDLE/HALTED→restart CPU and run; PAUSED→resume
//  step         in   1           pulse: PAUSED→execute exactly one instruction
//  stop         in   1           pulse: RUN→PAUSED
//  bp_en        in   1           breakpoint enable
//  bp_addr      in   DATA_WIDTH  breakpoint PC (byte address, even)
//  pc           in   DATA_WIDTH  CPU program counter
//  ir           in   DATA_WIDTH  CPU instruction register (instruction at pc)
//  cpu_en       out  1           CPU advances one instruction on each clock edge where cpu_en=1
//  cpu_rst      out  1           CPU synchronous reset
//  halted       out  1           registered; 1 in HALTED
//  at_break     out  1           registered; 1 while PAUSED because of a breakpoint hit
//  busy         out  1           registered; 1 in RESET_CPU, RUN or STEP
//  instr_count  out  CNT_WIDTH   registered; instructions executed since last restart, saturating
//  state        out  3           registered; current FSM state encoding
// BEHAVIOUR
//  Reset: state=IDLE, halted=0, at_break=0, busy=0, instr_count=0, bp_skip=0; cpu_rst=1 while reset=1.
//  States: IDLE=0, RESET_CPU=1, RUN=2, STEP=3, PAUSED=4, HALTED=5; encodings 6-7 → IDLE next cycle.
//  cpu_rst = reset | (state==RESET_CPU). Combinational.
//  hit = bp_en & (pc==bp_addr) & ~bp_skip.
//  cpu_en = (state∈{RUN,STEP}) & (ir!=HALT_INSTR) & ~hit. Combinational, so the halt word and
//    the breakpointed instruction never execute in the cycle they are detected.
//  IDLE: start→RESET_CPU. step/stop are ignored.
//  RESET_CPU: lasts exactly 1 cycle; instr_count←0, bp_skip←0 → RUN.
//  RUN, priority halt > breakpoint > stop:
//    ir==HALT_INSTR→HALTED. hit→PAUSED with at_break←1. stop→PAUSED.
//    Otherwise stay in RUN.
//  STEP: ir==HALT_INSTR→HALTED. hit→PAUSED with at_break←1 and no execution.
//    Otherwise execute 1 instruction (cpu_en=1 for exactly 1 cycle) → PAUSED.
//  PAUSED: start→RUN. step→STEP. start and step together: start wins.
//    On leaving PAUSED with at_break=1: bp_skip←1 and at_break←0, so the breakpointed
//    instruction then executes. bp_skip←0 after the first cpu_en=1 cycle.
//  HALTED: halted=1. start→RESET_CPU (full restart). step/stop are ignored.
//  instr_count += 1 on every edge with cpu_en=1; holds at 2^CNT_WIDTH-1.
//  Register outputs update on the edge after a transition.
//  reset asserted mid-operation: the FSM returns to IDLE on that edge. The CPU is held in reset
//    for as long as reset=1. Pending pulses are discarded.
// STRUCTURE
//  Package cpu_ctrl_pkg: state localparams (IDLE..HALTED), HALT_INSTR default.
//  One sub-module: sat_counter #(CNT_WIDTH) (clock, reset, clr, inc → q), used for instr_count.
//  FSM, bp_skip and the output registers live in cpu_run_controller.
// TESTING  (the bench includes a CPU model: pc+=2 per cpu_en; standard 9-instruction program, halt at pc=18)
//  1 reset, start → cpu_rst=1 for 1 cycle, RUN; at pc=18 ir=FFFF: cpu_en=0 in that same cycle;
//    next cycle halted=1, instr_count=9, busy=0.
//  2 bp_en=1, bp_addr=8, start → PAUSED with at_break=1, pc=8, instr_count=4.
//    start → resumes and executes pc=8, halts with instr_count=9.
//  3 from PAUSED at pc=4: step ×3 → each step gives exactly one cpu_en pulse; pc goes 6, 8, 10;
//    state returns to 4 after each.
//  4 RUN with stop and a breakpoint hit on the same cycle → PAUSED with at_break=1.
//    start+step together in PAUSED → RUN.
//  5 reset asserted at pc=10 in RUN → next cycle state=0, cpu_rst=1, instr_count=0.
//    A new start reruns the program from pc=0.
//  6 CNT_WIDTH=3: run the 9-instruction program → instr_count saturates at 7.
//    A restart from HALTED clears instr_count to 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - run controller state encodings and default halt word
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET_CPU = 3'd1,
    RUN       = 3'd2,
    STEP      = 3'd3,
    PAUSED    = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - host/CPU-facing signal bundle of the run controller
interface cpu_run_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);

  logic                  start;
  logic                  step;
  logic                  stop;
  logic                  bp_en;
  logic [DATA_WIDTH-1:0] bp_addr;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic                  cpu_en;
  logic                  cpu_rst;
  logic                  halted;
  logic                  at_break;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  instr_count;
  logic [2:0]            state;

  modport master (
    output start, step, stop, bp_en, bp_addr, pc, ir,
    input  cpu_en, cpu_rst, halted, at_break, busy, instr_count, state
  );

  modport slave (
    input  start, step, stop, bp_en, bp_addr, pc, ir,
    output cpu_en, cpu_rst, halted, at_break, busy, instr_count, state
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that holds at all-ones
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/halt sequencer with PC breakpoint for the 16-bit CPU
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT),
  parameter int                    CNT_WIDTH  = 16
) (
  input logic                 clock,
  input logic                 reset,
  cpu_run_controller_if.slave bus
);

  state_t state_q, state_d;
  logic   at_break_q, at_break_d;
  logic   bp_skip_q, bp_skip_d;
  logic   halted_q, busy_q;
  logic   is_halt, hit, cpu_en;

  assign is_halt = (bus.ir == HALT_INSTR);
  assign hit     = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_skip_q;
  // Gated combinationally so neither the halt word nor a breakpointed instruction executes.
  assign cpu_en  = ((state_q == RUN) || (state_q == STEP)) && !is_halt && !hit;

  assign bus.cpu_en   = cpu_en;
  assign bus.cpu_rst  = reset || (state_q == RESET_CPU);
  assign bus.halted   = halted_q;
  assign bus.at_break = at_break_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

  always_comb begin
    state_d    = state_q;
    at_break_d = at_break_q;
    bp_skip_d  = bp_skip_q;
    if (cpu_en) bp_skip_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RESET_CPU;
      RESET_CPU: begin
        state_d   = RUN;
        bp_skip_d = 1'b0;
      end
      RUN: begin
        if (is_halt) begin
          state_d = HALTED;
        end else if (hit) begin
          state_d    = PAUSED;
          at_break_d = 1'b1;
        end else if (bus.stop) begin
          state_d = PAUSED;
        end
      end
      STEP: begin
        if (is_halt) begin
          state_d = HALTED;
        end else begin
          state_d = PAUSED;
          if (hit) at_break_d = 1'b1;
        end
      end
      PAUSED: begin
        if (bus.start || bus.step) begin
          state_d = bus.start ? RUN : STEP;
          // Let the instruction we stopped on execute once before the breakpoint re-arms.
          if (at_break_q) begin
            bp_skip_d  = 1'b1;
            at_break_d = 1'b0;
          end
        end
      end
      HALTED: if (bus.start) state_d = RESET_CPU;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      at_break_q <= 1'b0;
      bp_skip_q  <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      at_break_q <= at_break_d;
      bp_skip_q  <= bp_skip_d;
      halted_q   <= (state_d == HALTED);
      busy_q     <= (state_d == RESET_CPU) || (state_d == RUN) || (state_d == STEP);
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instr_count (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == RESET_CPU),
    .inc   (cpu_en),
    .q     (bus.instr_count)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed bench for cpu_run_controller with a small CPU model
module tb_cpu_run_controller;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  cpu_run_controller_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) bus_a ();
  cpu_run_controller_if #(.DATA_WIDTH(16), .CNT_WIDTH(3))  bus_b ();

  cpu_run_controller #(.DATA_WIDTH(16), .HALT_INSTR(16'hFFFF), .CNT_WIDTH(16)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a)
  );
  cpu_run_controller #(.DATA_WIDTH(16), .HALT_INSTR(16'hFFFF), .CNT_WIDTH(3)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b)
  );

  // Program: nine ordinary instructions at 0..16, halt word at 18.
  function automatic logic [15:0] prog(input logic [15:0] p);
    return (p == 16'd18) ? 16'hFFFF : {8'h10, p[7:0]};
  endfunction

  logic [15:0] pc_a, pc_b;
  always @(posedge clock) begin
    if (bus_a.cpu_rst) pc_a <= 16'd0;
    else if (bus_a.cpu_en) pc_a <= pc_a + 16'd2;
    if (bus_b.cpu_rst) pc_b <= 16'd0;
    else if (bus_b.cpu_en) pc_b <= pc_b + 16'd2;
  end
  assign bus_a.pc = pc_a;
  assign bus_a.ir = prog(pc_a);
  assign bus_b.pc = pc_b;
  assign bus_b.ir = prog(pc_b);

  typedef struct {
    logic        start, step, stop;
    logic [2:0]  st;
    logic [15:0] pc;
    logic [15:0] cnt;
    logic        busy, en, rst;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_a(input logic s, input logic st, input logic sp);
    bus_a.start = s; bus_a.step = st; bus_a.stop = sp;
    cyc();
    bus_a.start = 1'b0; bus_a.step = 1'b0; bus_a.stop = 1'b0;
  endtask

  task automatic wait_state_a(input logic [2:0] st, input int max, input string name);
    int n = 0;
    while (bus_a.state !== st && n < max) begin cyc(); n++; end
    chk(name, bus_a.state, st);
  endtask

  task automatic wait_pc_a(input logic [15:0] p, input int max, input string name);
    int n = 0;
    while (bus_a.pc !== p && n < max) begin cyc(); n++; end
    chk(name, bus_a.pc, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    int n;
    bus_a.start = 0; bus_a.step = 0; bus_a.stop = 0; bus_a.bp_en = 0; bus_a.bp_addr = 0;
    bus_b.start = 0; bus_b.step = 0; bus_b.stop = 0; bus_b.bp_en = 0; bus_b.bp_addr = 0;
    reset = 1'b1;
    @(negedge clock);
    cyc();
    chk("rst_state", bus_a.state, 3'd0);
    chk("rst_halted", bus_a.halted, 1'b0);
    chk("rst_at_break", bus_a.at_break, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_count", bus_a.instr_count, 16'd0);
    chk("rst_cpu_rst", bus_a.cpu_rst, 1'b1);
    chk("rst_count_b", bus_b.instr_count, 3'd0);
    reset = 1'b0;
    cyc();
    chk("idle_cpu_rst", bus_a.cpu_rst, 1'b0);

    // start step stop | state pc cnt busy cpu_en cpu_rst
    tbl[0] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd2, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd2, 16'd2, 16'd1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 3'd4, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd3, 16'd4, 16'd2, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd4, 16'd6, 16'd3, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 3'd2, 16'd6, 16'd3, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      pulse_a(tbl[i].start, tbl[i].step, tbl[i].stop);
      chk($sformatf("tbl%0d_state", i), bus_a.state, tbl[i].st);
      chk($sformatf("tbl%0d_pc", i), bus_a.pc, tbl[i].pc);
      chk($sformatf("tbl%0d_count", i), bus_a.instr_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), bus_a.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_cpu_en", i), bus_a.cpu_en, tbl[i].en);
      chk($sformatf("tbl%0d_cpu_rst", i), bus_a.cpu_rst, tbl[i].rst);
    end
    wait_state_a(3'd5, 30, "tbl_halt_state");
    chk("tbl_halt_count", bus_a.instr_count, 16'd9);

    // Full run from HALTED: halt word blocks cpu_en in the cycle it is seen.
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("t1_reset_cpu", bus_a.state, 3'd1);
    chk("t1_cpu_rst", bus_a.cpu_rst, 1'b1);
    cyc();
    chk("t1_run", bus_a.state, 3'd2);
    chk("t1_count_clr", bus_a.instr_count, 16'd0);
    wait_pc_a(16'd18, 30, "t1_pc18");
    chk("t1_state_at_halt_word", bus_a.state, 3'd2);
    chk("t1_cpu_en_halt_word", bus_a.cpu_en, 1'b0);
    cyc();
    chk("t1_halted", bus_a.halted, 1'b1);
    chk("t1_count", bus_a.instr_count, 16'd9);
    chk("t1_busy", bus_a.busy, 1'b0);
    pulse_a(1'b0, 1'b1, 1'b1);
    chk("t1_halted_ignores", bus_a.state, 3'd5);

    // Breakpoint at 8, then resume through it.
    bus_a.bp_en = 1'b1; bus_a.bp_addr = 16'd8;
    pulse_a(1'b1, 1'b0, 1'b0);
    wait_state_a(3'd4, 30, "t2_paused");
    chk("t2_at_break", bus_a.at_break, 1'b1);
    chk("t2_pc", bus_a.pc, 16'd8);
    chk("t2_count", bus_a.instr_count, 16'd4);
    chk("t2_cpu_en_paused", bus_a.cpu_en, 1'b0);
    pulse_a(1'b1, 1'b0, 1'b0);
    chk("t2_resume_state", bus_a.state, 3'd2);
    chk("t2_resume_at_break", bus_a.at_break, 1'b0);
    chk("t2_resume_cpu_en", bus_a.cpu_en, 1'b1);
    wait_state_a(3'd5, 30, "t2_halt");
    chk("t2_final_count", bus_a.instr_count, 16'd9);

    // Single-step three times from a breakpoint at 4.
    bus_a.bp_addr = 16'd4;
    pulse_a(1'b1, 1'b0, 1'b0);
    wait_state_a(3'd4, 30, "t3_paused");
    chk("t3_pc0", bus_a.pc, 16'd4);
    for (int k = 0; k < 3; k++) begin
      pulse_a(1'b0, 1'b1, 1'b0);
      chk($sformatf("t3_step%0d_state", k), bus_a.state, 3'd3);
      en_cnt = int'(bus_a.cpu_en);
      cyc();
      en_cnt += int'(bus_a.cpu_en);
      chk($sformatf("t3_step%0d_pulses", k), en_cnt, 1);
      chk($sformatf("t3_step%0d_back", k), bus_a.state, 3'd4);
      chk($sformatf("t3_step%0d_pc", k), bus_a.pc, 16'd6 + 16'(2 * k));
      chk($sformatf("t3_step%0d_count", k), bus_a.instr_count, 16'd3 + 16'(k));
    end
    pulse_a(1'b1, 1'b0, 1'b0);
    wait_state_a(3'd5, 30, "t3_halt");

    // Stop and breakpoint hit on the same cycle; then start+step together.
    bus_a.bp_addr = 16'd6;
    pulse_a(1'b1, 1'b0, 1'b0);
    cyc();
    wait_pc_a(16'd6, 30, "t4_pc6");
    chk("t4_cpu_en_on_bp", bus_a.cpu_en, 1'b0);
    pulse_a(1'b0, 1'b0, 1'b1);
    chk("t4_paused", bus_a.state, 3'd4);
    chk("t4_at_break", bus_a.at_break, 1'b1);
    pulse_a(1'b1, 1'b1, 1'b0);
    chk("t4_start_wins", bus_a.state, 3'd2);
    chk("t4_cpu_en", bus_a.cpu_en, 1'b1);
    wait_state_a(3'd5, 30, "t4_halt");
    chk("t4_count", bus_a.instr_count, 16'd9);

    // Reset in the middle of a run, with a start pulse that must be dropped.
    bus_a.bp_en = 1'b0;
    pulse_a(1'b1, 1'b0, 1'b0);
    cyc();
    wait_pc_a(16'd10, 30, "t5_pc10");
    reset = 1'b1; bus_a.start = 1'b1;
    cyc();
    chk("t5_state", bus_a.state, 3'd0);
    chk("t5_cpu_rst", bus_a.cpu_rst, 1'b1);
    chk("t5_count", bus_a.instr_count, 16'd0);
    chk("t5_busy", bus_a.busy, 1'b0);
    chk("t5_pc", bus_a.pc, 16'd0);
    reset = 1'b0; bus_a.start = 1'b0;
    cyc();
    chk("t5_no_pending", bus_a.state, 3'd0);
    pulse_a(1'b1, 1'b0, 1'b0);
    cyc();
    chk("t5_rerun_state", bus_a.state, 3'd2);
    chk("t5_rerun_pc", bus_a.pc, 16'd0);
    wait_state_a(3'd5, 30, "t5_halt");
    chk("t5_final_count", bus_a.instr_count, 16'd9);

    // Narrow counter saturates, and a restart clears it.
    bus_b.start = 1'b1;
    cyc();
    bus_b.start = 1'b0;
    n = 0;
    while (bus_b.state !== 3'd5 && n < 30) begin cyc(); n++; end
    chk("t6_halt", bus_b.state, 3'd5);
    chk("t6_saturated", bus_b.instr_count, 3'd7);
    chk("t6_pc", bus_b.pc, 16'd18);
    bus_b.start = 1'b1;
    cyc();
    bus_b.start = 1'b0;
    chk("t6_restart_state", bus_b.state, 3'd1);
    cyc();
    chk("t6_restart_run", bus_b.state, 3'd2);
    chk("t6_restart_count", bus_b.instr_count, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
